// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Receives a little-endian byte stream, packs it into 32-bit instruction
// words and writes them to instruction memory while the core is held in
// reset. A word whose low seven bits are zero (the halt opcode) ends the
// load and releases the core; filling the memory without one flags an error.
module imem_boot_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE,
    ERR
  } state_t;

  // Word count of the last addressable word; writing it without a halt
  // opcode means memory is full.
  localparam logic [ADDR_W:0] LAST_WORD   = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] COUNT_STEP  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [6:0]      HALT_OPCODE = 7'b0000000;

  state_t      state;
  logic [1:0]  lane;
  // Lanes 0..2 of the word being assembled; lane 3 goes straight into
  // imem_wdata together with these when the word completes.
  logic [23:0] low_bytes;

  // Single state machine: all outputs are registered and set together with
  // the transition into the state that owns them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lane       <= 2'd0;
      low_bytes  <= 24'd0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      word_count <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= RECV;
            lane       <= 2'd0;
            byte_ready <= 1'b1;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            word_count <= '0;
          end
        end

        RECV: begin
          // byte_ready is always 1 here, so byte_valid alone means accepted.
          if (byte_valid) begin
            case (lane)
              2'd0: low_bytes[7:0]   <= byte_data;
              2'd1: low_bytes[15:8]  <= byte_data;
              2'd2: low_bytes[23:16] <= byte_data;
              default: begin
                imem_wdata <= {byte_data, low_bytes};
                imem_addr  <= word_count[ADDR_W-1:0];
                imem_we    <= 1'b1;
                byte_ready <= 1'b0;
                state      <= WRITE;
              end
            endcase
            // Wraps from 3 back to 0 as the word completes.
            lane <= lane + 2'd1;
          end
        end

        WRITE: begin
          // The strobe lasts exactly this one cycle.
          imem_we    <= 1'b0;
          word_count <= word_count + COUNT_STEP;
          if (imem_wdata[6:0] == HALT_OPCODE) begin
            state     <= DONE;
            cpu_hold  <= 1'b0;
            load_done <= 1'b1;
          end else if (word_count == LAST_WORD) begin
            state    <= ERR;
            load_err <= 1'b1;
          end else begin
            state      <= RECV;
            byte_ready <= 1'b1;
          end
        end

        default: begin
          state      <= IDLE;
          lane       <= 2'd0;
          byte_ready <= 1'b0;
          imem_we    <= 1'b0;
          cpu_hold   <= 1'b1;
          load_done  <= 1'b0;
          load_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader
// Table-driven loads, hand-written corner sequences and randomized loads
// checked against a word-list model of the boot loader.
module tb_imem_boot_loader;

  localparam int AW  = 2;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   word_count;

  imem_boot_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Free-running cycle counter used for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];
  logic [31:0]   cur_words[$];

  // Record every memory write, sampled away from the active edge.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      log_addr.push_back(imem_addr);
      log_data.push_back(imem_wdata);
    end
  end

  typedef struct {
    logic [3:0][31:0] w;
    int               n;
    int               gap;
    int               exp_writes;
    bit               exp_done;
    bit               exp_err;
    int               exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                         input logic [31:0] w3, input int n, input int gap, input int ew,
                         input bit ed, input int lat);
    vec_t v;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.n = n; v.gap = gap; v.exp_writes = ew;
    v.exp_done = ed; v.exp_err = !ed; v.exp_lat = lat;
    vecs.push_back(v);
  endtask

  // Reference: words are written in order from address 0; the load ends
  // after a halt-opcode word (done) or once memory is full (error).
  function automatic void ref_model(output int en, output bit edone);
    en = 0;
    edone = 1'b0;
    foreach (cur_words[i]) begin
      if (en == CAP) break;
      en++;
      if (cur_words[i][6:0] == 7'd0) begin
        edone = 1'b1;
        break;
      end
    end
  endfunction

  // All tasks below are entered and left just after a falling edge.
  task automatic do_reset();
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] b, input bit gap);
    bit ok;
    if (gap) begin
      byte_valid = 1'b0;
      byte_data = 8'($urandom);
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data = b;
    ok = 1'b0;
    for (int w = 0; w < 16; w++) begin
      if (byte_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    byte_valid = 1'b0;
    byte_data = 8'($urandom);
    checkOutput("byte_accepted", {31'd0, ok}, 32'd1);
  endtask

  // gap_mode: 0 = back-to-back, 1 = idle cycle before every byte, 2 = random.
  task automatic applyStimulus(input int n_drive, input int gap_mode, output int lat);
    int t0;
    logic [31:0] w;
    bit g;
    log_addr.delete();
    log_data.delete();
    pulse_start();
    t0 = cyc;
    for (int i = 0; i < n_drive; i++) begin
      w = cur_words[i];
      for (int l = 0; l < 4; l++) begin
        g = (gap_mode == 1) ? 1'b1 : (gap_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        drive_byte(w[8*l +: 8], g);
      end
    end
    for (int k = 0; k < 20; k++) begin
      if (load_done || load_err) break;
      @(negedge clk);
    end
    lat = cyc - t0;
  endtask

  task automatic check_load(input string tag, input int exp_n, input bit exp_done,
                            input bit exp_err, input int exp_lat, input int lat);
    checkOutput({tag, ".nwrites"}, log_data.size(), exp_n);
    for (int i = 0; i < exp_n && i < log_data.size(); i++) begin
      checkOutput($sformatf("%s.addr%0d", tag, i), {30'd0, log_addr[i]}, i);
      checkOutput($sformatf("%s.data%0d", tag, i), log_data[i], cur_words[i]);
    end
    checkOutput({tag, ".load_done"}, {31'd0, load_done}, {31'd0, exp_done});
    checkOutput({tag, ".load_err"}, {31'd0, load_err}, {31'd0, exp_err});
    checkOutput({tag, ".cpu_hold"}, {31'd0, cpu_hold}, {31'd0, !exp_done});
    checkOutput({tag, ".byte_ready"}, {31'd0, byte_ready}, 32'd0);
    checkOutput({tag, ".imem_we"}, {31'd0, imem_we}, 32'd0);
    checkOutput({tag, ".word_count"}, {29'd0, word_count}, exp_n);
    if (exp_lat >= 0) checkOutput({tag, ".latency"}, lat, exp_lat);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, en;
    bit ed;
    logic [31:0] w;

    // Table: words, count, gap mode, expected writes, done, latency (-1 = unchecked).
    add_vec(32'h0010_0513, 32'h0000_0000, 32'h0, 32'h0, 2, 0, 2, 1'b1, 10);
    add_vec(32'h0010_0513, 32'h0000_0000, 32'h0, 32'h0, 2, 1, 2, 1'b1, -1);
    add_vec(32'h0000_0013, 32'h0000_0013, 32'h0000_0013, 32'h0000_0013, 4, 0, 4, 1'b0, 20);
    add_vec(32'h0000_0000, 32'h0, 32'h0, 32'h0, 1, 0, 1, 1'b1, 5);
    add_vec(32'h1234_5677, 32'hABCD_EF80, 32'h0, 32'h0, 2, 1, 2, 1'b1, -1);
    add_vec(32'h0000_0001, 32'h0000_0040, 32'h0000_0013, 32'h0000_0000, 4, 0, 4, 1'b1, 20);

    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    checkOutput("rst.byte_ready", {31'd0, byte_ready}, 32'd0);
    checkOutput("rst.imem_we", {31'd0, imem_we}, 32'd0);
    checkOutput("rst.imem_addr", {30'd0, imem_addr}, 32'd0);
    checkOutput("rst.imem_wdata", imem_wdata, 32'd0);
    checkOutput("rst.cpu_hold", {31'd0, cpu_hold}, 32'd1);
    checkOutput("rst.load_done", {31'd0, load_done}, 32'd0);
    checkOutput("rst.load_err", {31'd0, load_err}, 32'd0);
    checkOutput("rst.word_count", {29'd0, word_count}, 32'd0);

    foreach (vecs[v]) begin
      do_reset();
      cur_words.delete();
      for (int i = 0; i < vecs[v].n; i++) cur_words.push_back(vecs[v].w[i]);
      applyStimulus(vecs[v].n, vecs[v].gap, lat);
      check_load($sformatf("vec%0d", v), vecs[v].exp_writes, vecs[v].exp_done,
                 vecs[v].exp_err, vecs[v].exp_lat, lat);
    end

    // Start from ERR restarts cleanly.
    do_reset();
    cur_words = '{32'h13, 32'h13, 32'h13, 32'h13};
    applyStimulus(4, 0, lat);
    pulse_start();
    checkOutput("err_restart.load_err", {31'd0, load_err}, 32'd0);
    checkOutput("err_restart.cpu_hold", {31'd0, cpu_hold}, 32'd1);
    checkOutput("err_restart.byte_ready", {31'd0, byte_ready}, 32'd1);
    checkOutput("err_restart.word_count", {29'd0, word_count}, 32'd0);

    // Reset mid-load discards the partial word and never writes it.
    do_reset();
    log_addr.delete(); log_data.delete();
    pulse_start();
    drive_byte(8'hAA, 1'b0);
    drive_byte(8'hBB, 1'b0);
    reset = 1'b1; byte_valid = 1'b1; byte_data = 8'hCC;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    checkOutput("midrst.byte_ready", {31'd0, byte_ready}, 32'd0);
    checkOutput("midrst.nwrites", log_data.size(), 32'd0);
    byte_valid = 1'b0;
    pulse_start();
    drive_byte(8'h13, 1'b0); drive_byte(8'h22, 1'b0);
    drive_byte(8'h33, 1'b0); drive_byte(8'h44, 1'b0);
    @(negedge clk);
    checkOutput("midrst.nwrites_after", log_data.size(), 32'd1);
    if (log_data.size() > 0) begin
      checkOutput("midrst.addr", {30'd0, log_addr[0]}, 32'd0);
      checkOutput("midrst.data", log_data[0], 32'h4433_2213);
    end

    // Start is ignored in RECV (during an idle cycle) and in WRITE.
    do_reset();
    log_addr.delete(); log_data.delete();
    pulse_start();
    drive_byte(8'h11, 1'b0); drive_byte(8'h22, 1'b0);
    pulse_start();
    drive_byte(8'h33, 1'b0); drive_byte(8'h44, 1'b0);
    pulse_start();
    checkOutput("ignstart.nwrites", log_data.size(), 32'd1);
    if (log_data.size() > 0) checkOutput("ignstart.data", log_data[0], 32'h4433_2211);
    checkOutput("ignstart.word_count", {29'd0, word_count}, 32'd1);
    checkOutput("ignstart.byte_ready", {31'd0, byte_ready}, 32'd1);

    // Reload from DONE.
    do_reset();
    cur_words = '{32'h0000_0000};
    applyStimulus(1, 0, lat);
    log_addr.delete(); log_data.delete();
    pulse_start();
    checkOutput("reload.cpu_hold", {31'd0, cpu_hold}, 32'd1);
    checkOutput("reload.load_done", {31'd0, load_done}, 32'd0);
    checkOutput("reload.word_count", {29'd0, word_count}, 32'd0);
    drive_byte(8'h33, 1'b0); drive_byte(8'h00, 1'b0);
    drive_byte(8'h00, 1'b0); drive_byte(8'h00, 1'b0);
    @(negedge clk);
    checkOutput("reload.nwrites", log_data.size(), 32'd1);
    if (log_data.size() > 0) begin
      checkOutput("reload.addr", {30'd0, log_addr[0]}, 32'd0);
      checkOutput("reload.data", log_data[0], 32'h0000_0033);
    end

    // Randomized loads, sometimes restarted straight from DONE/ERR.
    do_reset();
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 3) == 0) do_reset();
      cur_words.delete();
      for (int i = 0; i < CAP + 1; i++) begin
        w = $urandom;
        if ($urandom_range(0, 3) == 0) w[6:0] = 7'd0;
        else if (w[6:0] == 7'd0) w[0] = 1'b1;
        cur_words.push_back(w);
      end
      ref_model(en, ed);
      applyStimulus(en, 2, lat);
      check_load($sformatf("rand%0d", r), en, ed, !ed, -1, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
